if_fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory req/ack

---
 rtl/if_fetch_stage_pkg.sv | 20 ++
 rtl/if_fetch_stage_if.sv | 23 ++
 rtl/if_fetch_stage_if_id_reg.sv | 35 +++
 rtl/if_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] PC_INC        = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } fetch_state_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus seen by the fetch stage.
interface if_fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
import if_fetch_stage_pkg::*;

module if_fetch_stage_if_id_reg #(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  // Load has priority over bubble; with neither asserted the register holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= NOP_INSTR;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end else if (bubble) begin
      instr <= NOP_INSTR;
      pc4   <= 32'd0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC, fetch FSM, one-entry skid buffer, IF/ID register.
import if_fetch_stage_pkg::*;

module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pcwrite,
  input  logic                    ifwrite,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             if_id_instr,
  output logic [31:0]             if_id_pc4,
  output logic                    if_id_valid
);

  fetch_state_t state_r, state_nxt;
  logic [31:0]  pc_r, pc_nxt;
  logic [31:0]  req_addr_r, req_addr_nxt;
  logic [31:0]  skid_instr_r, skid_instr_nxt;
  logic [31:0]  skid_pc4_r, skid_pc4_nxt;
  logic         skid_valid_r, skid_valid_nxt;
  logic         imem_req_r, req_nxt_s;

  logic         advance_s, ack_s;
  logic [31:0]  pc_plus4_s, target_s;
  logic         ifid_load_s, ifid_bubble_s;
  logic [31:0]  ifid_instr_s, ifid_pc4_s;

  assign advance_s  = pcwrite & ifwrite;
  assign ack_s      = imem.imem_ack & imem_req_r;   // ack only counts while requesting
  assign pc_plus4_s = pc_r + PC_INC;                // wraps naturally at 32 bits
  assign target_s   = word_align(redirect_pc);
  assign req_nxt_s  = (state_nxt == S_REQ) || (state_nxt == S_DROP);

  assign imem.imem_req  = imem_req_r;
  assign imem.imem_addr = req_addr_r;

  // Next-state, PC, skid buffer and IF/ID control; redirect outranks every stall.
  always_comb begin
    state_nxt      = state_r;
    pc_nxt         = pc_r;
    req_addr_nxt   = req_addr_r;
    skid_instr_nxt = skid_instr_r;
    skid_pc4_nxt   = skid_pc4_r;
    skid_valid_nxt = skid_valid_r;
    ifid_load_s    = 1'b0;
    ifid_bubble_s  = 1'b0;
    ifid_instr_s   = imem.imem_rdata;
    ifid_pc4_s     = pc_plus4_s;

    if (redirect_valid) begin
      ifid_bubble_s  = 1'b1;
      skid_valid_nxt = 1'b0;
      pc_nxt         = target_s;
      case (state_r)
        S_REQ: begin
          if (ack_s) begin
            req_addr_nxt = target_s;
            state_nxt    = S_REQ;
          end else begin
            state_nxt    = S_DROP;     // old request must complete first
          end
        end
        S_DROP: begin
          if (ack_s) begin
            req_addr_nxt = target_s;
            state_nxt    = S_REQ;
          end else begin
            state_nxt    = S_DROP;
          end
        end
        default: begin                 // S_IDLE, S_HOLD: nothing in flight
          req_addr_nxt = target_s;
          state_nxt    = S_REQ;
        end
      endcase
    end else begin
      case (state_r)
        S_IDLE: begin
          req_addr_nxt = pc_r;
          state_nxt    = S_REQ;
        end
        S_REQ: begin
          if (ack_s && advance_s) begin
            ifid_load_s  = 1'b1;
            pc_nxt       = pc_plus4_s;
            req_addr_nxt = pc_plus4_s;
          end else if (ack_s) begin
            skid_instr_nxt = imem.imem_rdata;
            skid_pc4_nxt   = pc_plus4_s;
            skid_valid_nxt = 1'b1;
            ifid_bubble_s  = ifwrite;
            state_nxt      = S_HOLD;
          end else begin
            ifid_bubble_s  = ifwrite;
          end
        end
        S_HOLD: begin
          if (advance_s) begin
            ifid_load_s    = 1'b1;
            ifid_instr_s   = skid_instr_r;
            ifid_pc4_s     = skid_pc4_r;
            skid_valid_nxt = 1'b0;
            pc_nxt         = pc_plus4_s;
            req_addr_nxt   = pc_plus4_s;
            state_nxt      = S_REQ;
          end else begin
            ifid_bubble_s  = ifwrite;
          end
        end
        S_DROP: begin
          ifid_bubble_s = ifwrite;
          if (ack_s) begin
            req_addr_nxt = pc_r;       // discard stale word, fetch the redirect target
            state_nxt    = S_REQ;
          end else begin
            state_nxt    = S_DROP;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Fetch state, PC, request address/strobe and skid buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      pc_r         <= RESET_PC;
      req_addr_r   <= RESET_PC;
      imem_req_r   <= 1'b0;
      skid_instr_r <= NOP_INSTR;
      skid_pc4_r   <= 32'd0;
      skid_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      pc_r         <= pc_nxt;
      req_addr_r   <= req_addr_nxt;
      imem_req_r   <= req_nxt_s;
      skid_instr_r <= skid_instr_nxt;
      skid_pc4_r   <= skid_pc4_nxt;
      skid_valid_r <= skid_valid_nxt;
    end
  end

  if_fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load_s),
    .bubble   (ifid_bubble_s),
    .instr_in (ifid_instr_s),
    .pc4_in   (ifid_pc4_s),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

endmodule
